// File: rtl/rep_seq_gen.sv
// rep_seq_gen: stimulus generator for the req ##1 busy[*N] ##1 ready[*1:$] protocol.
//
// A transaction starts when `start` is seen in IDLE. The block then runs
// REQ (1 cycle), BUSY (N cycles) and READY (until `ack`), and returns to IDLE.
// N = clamp(len, MIN_REP, MAX_REP) is latched when the transaction starts.
//
// Ports:
//   clk      in  1   clock, all state updates on posedge
//   rst      in  1   asynchronous active-high reset
//   start    in  1   request a transaction (sampled only in IDLE)
//   len      in  CW  requested busy run length (sampled with start)
//   ack      in  1   consumer acknowledge, ends READY
//   accept   out 1   pulse in the first REQ cycle when start was taken
//   clamped  out 1   pulse with accept when len was out of range
//   req      out 1   high in REQ
//   busy     out 1   high in BUSY
//   ready    out 1   high in READY
//   state    out 4   IDLE=0, REQ=1, BUSY=3, READY=4
//
// Optional feature: define REP_SEQ_GEN_ASSERT_EN to elaborate protocol
// assertions on the block's own outputs.
module rep_seq_gen #(
    parameter int unsigned MIN_REP = 2,
    parameter int unsigned MAX_REP = 4,
    parameter int unsigned CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic          ack,
    output logic          accept,
    output logic          clamped,
    output logic          req,
    output logic          busy,
    output logic          ready,
    output logic [3:0]    state
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_REQ   = 4'd1;
    localparam logic [3:0] ST_BUSY  = 4'd3;
    localparam logic [3:0] ST_READY = 4'd4;

    localparam logic [CW-1:0] MIN_C = CW'(MIN_REP);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_REP);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] n_q, n_d;
    logic          accept_q, accept_d;
    logic          clamped_q, clamped_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        accept_d  = 1'b0;
        clamped_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_d = 1'b1;
                    state_d  = ST_REQ;
                    if (len < MIN_C) begin
                        n_d       = MIN_C;
                        clamped_d = 1'b1;
                    end else if (len > MAX_C) begin
                        n_d       = MAX_C;
                        clamped_d = 1'b1;
                    end else begin
                        n_d = len;
                    end
                end
            end
            ST_REQ: begin
                // Counter holds the number of BUSY cycles still to follow.
                cnt_d   = n_q - ONE_C;
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            ST_READY: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            accept_q  <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            accept_q  <= accept_d;
            clamped_q <= clamped_d;
        end
    end

    assign accept  = accept_q;
    assign clamped = clamped_q;
    assign req     = (state_q == ST_REQ);
    assign busy    = (state_q == ST_BUSY);
    assign ready   = (state_q == ST_READY);
    assign state   = state_q;

`ifdef REP_SEQ_GEN_ASSERT_EN
    // Length of the current busy run; holds the finished run length in the
    // cycle busy falls.
    logic [CW-1:0] busy_run_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_run_q <= '0;
        end else if (busy) begin
            busy_run_q <= busy_run_q + ONE_C;
        end else begin
            busy_run_q <= '0;
        end
    end

    a_req_then_busy: assert property (@(posedge clk) disable iff (rst)
        req |=> busy);
    a_run_len_lat: assert property (@(posedge clk) disable iff (rst)
        $fell(busy) |-> (busy_run_q == n_q) && ready);
    a_run_len_bound: assert property (@(posedge clk) disable iff (rst)
        $fell(busy) |-> (busy_run_q >= MIN_C) && (busy_run_q <= MAX_C));
    a_busy_to_ready: assert property (@(posedge clk) disable iff (rst)
        (state == ST_BUSY) |=> (state == ST_BUSY) || (state == ST_READY));
    a_ready_hold: assert property (@(posedge clk) disable iff (rst)
        ready && !ack |=> ready);
    a_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0({req, busy, ready}));
`endif

endmodule

// File: tb/tb_rep_seq_gen.sv
// Directed bench for rep_seq_gen with default parameters (MIN 2, MAX 4, CW 4).
// Each vector drives inputs, waits one rising edge, then checks the outputs.
module tb_rep_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       ack;
    logic       accept;
    logic       clamped;
    logic       req;
    logic       busy;
    logic       ready;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    rep_seq_gen #(
        .MIN_REP(2),
        .MAX_REP(4),
        .CW     (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .len    (len),
        .ack    (ack),
        .accept (accept),
        .clamped(clamped),
        .req    (req),
        .busy   (busy),
        .ready  (ready),
        .state  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [3:0] len;
        logic       ack;
        logic       e_accept;
        logic       e_clamped;
        logic       e_req;
        logic       e_busy;
        logic       e_ready;
        logic [3:0] e_state;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [3:0] l, input logic a,
                       input logic ea, input logic ec, input logic er,
                       input logic eb, input logic ey, input logic [3:0] es);
        vec_t v;
        v.start = s; v.len = l; v.ack = a;
        v.e_accept = ea; v.e_clamped = ec; v.e_req = er;
        v.e_busy = eb; v.e_ready = ey; v.e_state = es;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, " accept"}, {3'b0, accept}, {3'b0, v.e_accept});
        chk({tag, " clamped"}, {3'b0, clamped}, {3'b0, v.e_clamped});
        chk({tag, " req"}, {3'b0, req}, {3'b0, v.e_req});
        chk({tag, " busy"}, {3'b0, busy}, {3'b0, v.e_busy});
        chk({tag, " ready"}, {3'b0, ready}, {3'b0, v.e_ready});
        chk({tag, " state"}, state, v.e_state);
    endtask

    task automatic apply(input string tag, input vec_t v);
        start = v.start;
        len   = v.len;
        ack   = v.ack;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    vec_t hv;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = 4'd0;
        ack   = 1'b0;

        // Basic len=3 with ack tied high: states 1,3,3,3,4,0.
        //   start len  ack   acc clp req bsy rdy state
        add(1'b1, 4'd3, 1'b1, 1, 0, 1, 0, 0, 4'd1);
        add(1'b0, 4'd3, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd3, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd3, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd3, 1'b1, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd3, 1'b1, 0, 0, 0, 0, 0, 4'd0);
        // len=0 clamps to 2.
        add(1'b1, 4'd0, 1'b1, 1, 1, 1, 0, 0, 4'd1);
        add(1'b0, 4'd0, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd0, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd0, 1'b1, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd0, 1'b1, 0, 0, 0, 0, 0, 4'd0);
        // len=9 clamps to 4.
        add(1'b1, 4'd9, 1'b1, 1, 1, 1, 0, 0, 4'd1);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd9, 1'b1, 0, 0, 0, 0, 0, 4'd0);
        // len=4 (upper bound, no clamp); start pulsed in REQ/BUSY is ignored;
        // early ack is not remembered; ack low holds READY for 5 cycles.
        add(1'b1, 4'd4, 1'b0, 1, 0, 1, 0, 0, 4'd1);
        add(1'b1, 4'd2, 1'b0, 0, 0, 0, 1, 0, 4'd3);
        add(1'b1, 4'd9, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd4, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd4, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd4, 1'b0, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd4, 1'b0, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd4, 1'b0, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd4, 1'b0, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd4, 1'b0, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd4, 1'b1, 0, 0, 0, 0, 0, 4'd0);
        add(1'b0, 4'd4, 1'b1, 0, 0, 0, 0, 0, 4'd0);
        // len=2 (lower bound, no clamp).
        add(1'b1, 4'd2, 1'b1, 1, 0, 1, 0, 0, 4'd1);
        add(1'b0, 4'd2, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd2, 1'b1, 0, 0, 0, 1, 0, 4'd3);
        add(1'b0, 4'd2, 1'b1, 0, 0, 0, 0, 1, 4'd4);
        add(1'b0, 4'd2, 1'b1, 0, 0, 0, 0, 0, 4'd0);

        // Reset state.
        #12;
        hv = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        check_outs("reset", hv);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset in the 2nd BUSY cycle of len=4.
        hv = '{1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        apply("mrst req", hv);
        hv = '{1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3};
        apply("mrst busy1", hv);
        apply("mrst busy2", hv);
        #2 rst = 1'b1;
        #1;
        hv = '{1'b0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        check_outs("mrst async", hv);
        #1 rst = 1'b0;

        // Next transaction after reset runs normally (len=3).
        hv = '{1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
        apply("post req", hv);
        hv = '{1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3};
        apply("post busy1", hv);
        apply("post busy2", hv);
        apply("post busy3", hv);
        hv = '{1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4};
        apply("post ready", hv);
        hv = '{1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        apply("post idle", hv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rep_seq_gen.md
# rep_seq_gen

Synthesizable sequence generator that drives the request/busy/ready protocol checked by the consecutive-repetition assertion suite. It produces `req ##1 busy[*N] ##1 ready[*1:$]` with a programmable, range-clamped N, plus a 4-bit state output. It sits in the SVA test harness as the stimulus source for the repetition checkers. It also serves as a known-good DUT for formal flows.

## Interface
- `MIN_REP`, default 2: minimum busy run length; must be ≥1.
- `MAX_REP`, default 4: maximum busy run length; `MIN_REP ≤ MAX_REP < 2**CW`.
- `CW`, default 4: width of `len` and of the internal run counter.

Ports:
- `clk` in 1: single clock; all logic is on `posedge clk`.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a new transaction; sampled only in IDLE.
- `len` in CW: requested busy run length; sampled together with `start`.
- `ack` in 1: consumer acknowledge; terminates the READY phase.
- `accept` out 1: one-cycle pulse when `start` is taken.
- `clamped` out 1: one-cycle pulse, coincident with `accept`, when `len` was out of range.
- `req` out 1: high for exactly one cycle per transaction.
- `busy` out 1: high for exactly N consecutive cycles.
- `ready` out 1: high from the end of busy until `ack`.
- `state` out 4: FSM encoding.

## Operation
- FSM states and `state` encodings:
  - IDLE = 4'd0
  - REQ = 4'd1
  - BUSY = 4'd3
  - READY = 4'd4
  - No other values are ever driven.
- IDLE:
  - If `start` is high, latch N = clamp(`len`, MIN_REP, MAX_REP), pulse `accept`, and go to REQ.
  - Otherwise stay in IDLE.
- Clamping:
  - `len` < MIN_REP gives N = MIN_REP.
  - `len` > MAX_REP gives N = MAX_REP.
  - Either case pulses `clamped`.
  - `len` = 0 clamps to MIN_REP.
- REQ: lasts one cycle, then go unconditionally to BUSY with counter = N−1.
- BUSY:
  - Decrement the counter each cycle.
  - When the counter is 0, go to READY.
  - This yields exactly N BUSY cycles.
  - `ack` and `start` are ignored.
- READY:
  - Stay in READY while `ack` is low.
  - `ack` high goes to IDLE on the next edge.
- `start` outside IDLE is ignored: no queueing, no `accept`.
- Outputs are decoded from registered state:
  - `req` = (state == REQ)
  - `busy` = (state == BUSY)
  - `ready` = (state == READY)
- `accept` and `clamped` are registered pulses asserted in the cycle after `start` is sampled, which is the first REQ cycle.
- Reset values:
  - All outputs are 0 and the FSM is IDLE.
  - Counter and latched N are 0.

## Timing
- `start` sampled at edge t gives:
  - `req`, `accept`, `clamped` high in cycle t+1.
  - `busy` high in cycles t+2 … t+1+N.
  - `ready` high from cycle t+2+N.
- `ack` sampled high at edge u while READY gives `ready` low and IDLE from cycle u+1.
- The earliest next `start` sample is edge u+1, so the minimum transaction period is N+3 cycles with `ack` tied high.
- `ack` high before READY has no effect and is not remembered.
- `rst` asserted mid-transaction (any state) clears all outputs immediately, without waiting for a clock edge.
  - After `rst` deasserts, the first `start` sample edge is the first `clk` edge after deassertion.
- At most one of `req`, `busy`, `ready` is high in any cycle.

## Configuration
- `REP_SEQ_GEN_ASSERT_EN` defined: the block compiles in concurrent assertions on its own outputs, all clocked `@(posedge clk)` and disabled iff `rst`:
  - `req |=> busy[*N_lat] ##1 ready`, with N_lat being the latched N.
  - `busy[*MIN_REP:MAX_REP]` bound on every busy run.
  - `(state == 4'd3)[*1:$] ##1 (state == 4'd4)`.
  - `ready && !ack |=> ready`.
  - Onehot0 of {`req`, `busy`, `ready`}.
- Not defined: no assertion code is elaborated; RTL behaviour is identical.

## Test plan
- Reset, then `start`=1, `len`=3, `ack`=1: `req` at t+1; `busy` cycles t+2..t+4; `ready` at t+5; `state` sequence 1,3,3,3,4,0.
- `len`=0 and `len`=9 with default params: `clamped` pulses; busy runs are 2 and 4 cycles respectively.
- `ack` held low for 5 cycles after READY entry: `ready` and `state`=4 hold for 5 cycles; IDLE the cycle after `ack` is sampled high.
- `start` pulsed during REQ and BUSY: no `accept`; the in-flight busy run length is unchanged.
- `rst` asserted in the 2nd BUSY cycle of `len`=4: `busy`, `state` go to 0 immediately; the next transaction after deassertion runs normally.
- Build with `REP_SEQ_GEN_ASSERT_EN`, random `start`/`len`/`ack` for 10k cycles: zero assertion failures.
